// File: rtl/ov7670_capture.sv
// OV7670 parallel capture: registers VSYNC/HREF/D, pairs bytes into RGB565 pixels with a linear write address.
// Optional 2:1 downscale (even pixels of even lines) when CAPTURE_DECIMATE_EN is defined.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              config_done,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              line_err,
    output logic [7:0]        frame_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SYNC    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    // Pixel counter saturates one past H_ACTIVE so over-long lines stay flagged.
    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [PW-1:0] H_LIM = PW'(H_ACTIVE);
    localparam logic [PW-1:0] H_SAT = PW'(H_ACTIVE + 1);
    localparam logic [LW-1:0] V_LIM = LW'(V_ACTIVE);
`ifdef CAPTURE_DECIMATE_EN
    localparam int PIX_TOTAL = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
    localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
`endif
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(PIX_TOTAL - 1);

    logic              vsync_q, vsync_d, href_q, href_d;
    logic [7:0]        d_q, d_d;
    logic              vsync_p_q, vsync_p_d, href_p_q, href_p_d;
    logic [1:0]        state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]     line_cnt_q, line_cnt_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic vs_rise, vs_fall, hr_fall, line_ok, pix_ok, keep;

    assign vs_rise = vsync_q & ~vsync_p_q;
    assign vs_fall = ~vsync_q & vsync_p_q;
    assign hr_fall = ~href_q & href_p_q;
    assign line_ok = (line_cnt_q < V_LIM);
    assign pix_ok  = (pix_cnt_q < H_LIM);
`ifdef CAPTURE_DECIMATE_EN
    assign keep = ~line_cnt_q[0] & ~pix_cnt_q[0];
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        vsync_d       = vsync;
        href_d        = href;
        d_d           = d;
        vsync_p_d     = vsync_q;
        href_p_d      = href_q;
        state_d       = state_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        addr_cnt_d    = addr_cnt_q;
        pix_data_d    = pix_data_q;
        pix_addr_d    = pix_addr_q;
        frame_count_d = frame_count_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                phase_d = 1'b0;
                if (config_done) state_d = S_SYNC;
            end
            S_SYNC: begin
                phase_d = 1'b0;
                if (vs_fall) begin
                    frame_start_d = 1'b1;
                    addr_cnt_d    = '0;
                    line_cnt_d    = '0;
                    pix_cnt_d     = '0;
                    state_d       = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (vs_rise) begin
                    // A line cut short by VSYNC loses its partial pixel and is reported.
                    frame_done_d  = 1'b1;
                    line_err_d    = href_q;
                    frame_count_d = frame_count_q + 8'd1;
                    phase_d       = 1'b0;
                    state_d       = S_SYNC;
                end else if (href_q) begin
                    if (!phase_q) begin
                        hi_d    = d_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (pix_cnt_q != H_SAT) pix_cnt_d = pix_cnt_q + PW'(1);
                        if (line_ok && pix_ok && keep) begin
                            pix_data_d  = {hi_q, d_q};
                            pix_valid_d = 1'b1;
                            pix_addr_d  = addr_cnt_q;
                            if (addr_cnt_q != ADDR_MAX) addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                        end
                    end
                end else if (hr_fall) begin
                    line_err_d = phase_q | (pix_cnt_q != H_LIM);
                    phase_d    = 1'b0;
                    pix_cnt_d  = '0;
                    if (line_ok) line_cnt_d = line_cnt_q + LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing configuration abandons the frame without completing it.
        if (!config_done) begin
            state_d       = S_IDLE;
            phase_d       = 1'b0;
            pix_valid_d   = 1'b0;
            frame_start_d = 1'b0;
            frame_done_d  = 1'b0;
            line_err_d    = 1'b0;
            frame_count_d = frame_count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            d_q           <= '0;
            vsync_p_q     <= 1'b0;
            href_p_q      <= 1'b0;
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            addr_cnt_q    <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_addr_q    <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            d_q           <= d_d;
            vsync_p_q     <= vsync_p_d;
            href_p_q      <= href_p_d;
            state_q       <= state_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_addr_q    <= pix_addr_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_addr    = pix_addr_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: frame table plus hand sequences, pixels checked through a scoreboard queue.
module tb_ov7670_capture;

    localparam int H  = 4;
`ifdef CAPTURE_DECIMATE_EN
    localparam int V   = 4;
    localparam bit DEC = 1'b1;
`else
    localparam int V   = 3;
    localparam bit DEC = 1'b0;
`endif
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          config_done = 1'b1;
    logic          vsync = 1'b1;
    logic          href = 1'b0;
    logic [7:0]    d = 8'h00;
    logic [15:0]   pix_data;
    logic          pix_valid;
    logic [AW-1:0] pix_addr;
    logic          frame_start, frame_done, line_err;
    logic [7:0]    frame_count;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .config_done(config_done),
        .vsync(vsync), .href(href), .d(d),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_addr(pix_addr),
        .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   data;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct {
        int nlines;
        int nbytes;
        int exp_pv;
        int exp_le;
    } vec_t;

    exp_t     sbq[$];
    exp_t     e;
    vec_t     vt[5];
    int       checks = 0, errors = 0;
    int       n_pv, n_fs, n_fd, n_le, n_co;
    int       m_addr, m_line, m_pushed, m_lerr, m_fc;
    bit       cap;
    logic [7:0] bctr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                n_pv++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL pix unexpected strobe got %h@%0d want none", pix_data, pix_addr);
                end else begin
                    e = sbq.pop_front();
                    if (pix_data !== e.data || pix_addr !== e.addr) begin
                        errors++;
                        $display("FAIL pix got %h@%0d want %h@%0d", pix_data, pix_addr, e.data, e.addr);
                    end
                end
            end
            if (frame_start) n_fs++;
            if (frame_done) n_fd++;
            if (line_err) n_le++;
            if (line_err && frame_done) n_co++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp_v);
        end
    endtask

    function automatic bit keep(input int l, input int p);
        return (l < V) && (p < H) && (!DEC || ((l % 2) == 0 && (p % 2) == 0));
    endfunction

    task automatic push(input logic [7:0] hi, input logic [7:0] lo);
        sbq.push_back('{data: {hi, lo}, addr: AW'(m_addr)});
        m_addr++;
        m_pushed++;
    endtask

    task automatic drv(input logic v, input logic h, input logic [7:0] x);
        @(negedge clk);
        vsync = v; href = h; d = x;
    endtask

    task automatic clr();
        @(posedge clk); #1;
        n_pv = 0; n_fs = 0; n_fd = 0; n_le = 0; n_co = 0;
        m_pushed = 0; m_lerr = 0;
    endtask

    task automatic frame_begin();
        repeat (4) drv(1'b1, 1'b0, 8'h00);
        repeat (3) drv(1'b0, 1'b0, 8'h00);
        m_addr = 0; m_line = 0;
    endtask

    task automatic frame_end();
        repeat (3) drv(1'b1, 1'b0, 8'h00);
    endtask

    // drop >= 0: config_done falls while that byte is driven
    task automatic line(input int nb, input int drop);
        logic [7:0] hi, b;
        hi = 8'h00;
        for (int j = 0; j < nb; j++) begin
            b = bctr; bctr = bctr + 8'd1;
            @(negedge clk);
            if (j == drop) config_done = 1'b0;
            vsync = 1'b0; href = 1'b1; d = b;
            if (j % 2 == 0) hi = b;
            else if (cap && (drop < 0 || j <= drop - 2) && keep(m_line, j / 2)) push(hi, b);
        end
        if (drop >= 0) cap = 1'b0;
        repeat (4) drv(1'b0, 1'b0, 8'h00);
        if (cap && ((nb % 2) != 0 || (nb / 2) != H)) m_lerr++;
        m_line++;
    endtask

    task automatic end_check(input string nm, input int pv, input int le, input int fs, input int fd);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        chk({nm, " pix_count"}, pv, n_pv);
        chk({nm, " line_err"}, n_le, le);
        chk({nm, " frame_start"}, n_fs, fs);
        chk({nm, " frame_done"}, n_fd, fd);
        chk({nm, " frame_count"}, {24'h0, frame_count}, m_fc % 256);
        chk({nm, " queue_left"}, sbq.size(), 0);
    endtask

    initial begin
        logic [7:0] hi, b;
`ifdef CAPTURE_DECIMATE_EN
        vt[0] = '{4, 8, 4, 0};
        vt[1] = '{3, 9, 4, 3};
        vt[2] = '{5, 12, 4, 5};
        vt[3] = '{5, 8, 4, 0};
        vt[4] = '{2, 6, 2, 2};
`else
        vt[0] = '{3, 8, 12, 0};
        vt[1] = '{3, 9, 12, 3};
        vt[2] = '{5, 12, 12, 5};
        vt[3] = '{5, 8, 12, 0};
        vt[4] = '{2, 6, 6, 2};
`endif
        cap = 1'b1; m_fc = 0; bctr = 8'h01;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pix_data", {16'h0, pix_data}, 0);
        chk("rst pix_valid", {31'h0, pix_valid}, 0);
        chk("rst pix_addr", {13'h0, pix_addr}, 0);
        chk("rst frame_start", {31'h0, frame_start}, 0);
        chk("rst frame_done", {31'h0, frame_done}, 0);
        chk("rst line_err", {31'h0, line_err}, 0);
        chk("rst frame_count", {24'h0, frame_count}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clr();
            bctr = 8'h01;
            frame_begin();
            for (int l = 0; l < vt[i].nlines; l++) line(vt[i].nbytes, -1);
            frame_end();
            m_fc++;
            end_check($sformatf("vec%0d", i), vt[i].exp_pv, vt[i].exp_le, 1, 1);
        end

        // configuration arrives mid-frame: nothing until the next frame
        clr();
        config_done = 1'b0; cap = 1'b0;
        frame_begin();
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 3) config_done = 1'b1;
            vsync = 1'b0; href = 1'b1; d = bctr; bctr = bctr + 8'd1;
        end
        repeat (4) drv(1'b0, 1'b0, 8'h00);
        line(8, -1);
        frame_end();
        cap = 1'b1;
        frame_begin();
        for (int l = 0; l < 3; l++) line(8, -1);
        frame_end();
        m_fc++;
        end_check("cfgrise", m_pushed, m_lerr, 1, 1);

        // VSYNC rises while HREF is still high
        clr();
        frame_begin();
        line(8, -1);
        hi = 8'h00;
        for (int j = 0; j < 6; j++) begin
            b = bctr; bctr = bctr + 8'd1;
            @(negedge clk);
            vsync = (j == 5); href = 1'b1; d = b;
            if (j % 2 == 0) hi = b;
            else if (j < 5 && keep(m_line, j / 2)) push(hi, b);
        end
        drv(1'b1, 1'b1, 8'h00);
        repeat (3) drv(1'b1, 1'b0, 8'h00);
        m_fc++;
        end_check("vs_in_line", m_pushed, 1, 1, 1);
        chk("vs_in_line coincide", n_co, 1);

        // configuration lost after the fifth pixel
        clr();
        frame_begin();
        line(8, -1);
        line(8, 3);
        frame_end();
        end_check("cfgdrop", m_pushed, m_lerr, 1, 0);
        chk("cfgdrop pushed", m_pushed, DEC ? 2 : 5);
        config_done = 1'b1; cap = 1'b1;

        // asynchronous reset with a strobe in flight
        clr();
        frame_begin();
        hi = 8'h00;
        for (int j = 0; j < 4; j++) begin
            b = bctr; bctr = bctr + 8'd1;
            @(negedge clk);
            vsync = 1'b0; href = 1'b1; d = b;
            if (j % 2 == 0) hi = b;
            else if (keep(0, j / 2)) push(hi, b);
        end
        @(posedge clk);
        @(posedge clk); #1;
        chk("rstmid pv_before", {31'h0, pix_valid}, DEC ? 0 : 1);
        chk("rstmid fc_before", {24'h0, frame_count}, m_fc % 256);
        rst_n = 1'b0;
        #1;
        chk("rstmid pix_data", {16'h0, pix_data}, 0);
        chk("rstmid pix_valid", {31'h0, pix_valid}, 0);
        chk("rstmid pix_addr", {13'h0, pix_addr}, 0);
        chk("rstmid frame_count", {24'h0, frame_count}, 0);
        chk("rstmid line_err", {31'h0, line_err}, 0);
        chk("rstmid queue", sbq.size(), DEC ? 0 : 1);
        sbq.delete();
        m_fc = 0;
        @(negedge clk);
        rst_n = 1'b1; href = 1'b0; vsync = 1'b1;

        // frame counter wrap
        clr();
        for (int f = 0; f < 256; f++) begin
            frame_begin();
            frame_end();
            m_fc++;
            if (f == 254) end_check("wrap255", 0, 0, 255, 255);
        end
        end_check("wrap0", 0, 0, 256, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
